// File: rtl/metro_card_reader.sv
// -----------------------------------------------------------------------------
// metro_card_reader
//
// Front-end card reader for the metro turnstile. It receives a serial card
// frame, checks its start and even-parity bits, and presents the access code
// to the turnstile. The code is held on access_code with validate_code high
// until the turnstile acknowledges with open_access_door.
//
// If no acknowledge arrives within ACK_TIMEOUT cycles, the code is presented
// again after a one-cycle gap, up to MAX_RETRY more times. A bad frame, or
// running out of retries, gives a one-cycle reject pulse. After that the
// reader waits for the card to be removed.
//
// Frame (first bit on the wire first):
//   bit0          start bit, must be 1
//   bit1..CODE_W  access code, MSB first
//   last bit      even parity over the code bits
//
// Ports:
//   clk               system clock, rising edge
//   rset              asynchronous reset, active low
//   card_present      level, high while a card sits in the slot
//   card_bit          serial frame data, sampled when card_bit_valid = 1
//   card_bit_valid    one-cycle strobe per frame bit
//   open_access_door  acknowledge from the turnstile (level)
//   validate_code     high while a code is being presented
//   access_code       code under presentation, stable while validate_code = 1
//   reject            one-cycle pulse on bad frame or exhausted retries
//   busy              high in every state except IDLE
//   state_out         current state encoding (debug)
// -----------------------------------------------------------------------------
module metro_card_reader #(
  parameter int CODE_W      = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rset,
  input  logic              card_present,
  input  logic              card_bit,
  input  logic              card_bit_valid,
  input  logic              open_access_door,
  output logic              validate_code,
  output logic [CODE_W-1:0] access_code,
  output logic              reject,
  output logic              busy,
  output logic [2:0]        state_out
);

  localparam int FRAME_W = CODE_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RECV     = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_PRESENT  = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_REJECT   = 3'd6;
  localparam logic [2:0] S_WAIT_OUT = 3'd7;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       TMO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0]       TMO_ONE   = 8'd1;
  localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);
  localparam logic [2:0]       RETRY_ONE = 3'd1;

  logic [2:0]         state_q,    state_d;
  logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [FRAME_W-1:0] frame_q,    frame_d;
  logic [7:0]         tmo_q,      tmo_d;
  logic [2:0]         retry_q,    retry_d;
  logic [CODE_W-1:0]  code_q,     code_d;
  logic               validate_q, validate_d;
  logic               reject_q,   reject_d;
  logic               busy_q,     busy_d;

  // Frame fields. The shift register fills from the LSB, so the first bit
  // received (start) ends up at the MSB and the parity bit at bit 0.
  logic               frame_start;
  logic [CODE_W-1:0]  frame_code;
  logic               frame_parity;
  logic               frame_ok;

  assign frame_start  = frame_q[FRAME_W-1];
  assign frame_code   = frame_q[FRAME_W-2:1];
  assign frame_parity = frame_q[0];
  // Even parity: the XOR over the code bits and the parity bit must be 0.
  assign frame_ok     = frame_start & ~(^{frame_code, frame_parity});

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    code_d    = code_q;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        tmo_d     = '0;
        retry_d   = '0;
        if (card_present) begin
          state_d = S_RECV;
          // A strobe coincident with card insertion is the start bit.
          if (card_bit_valid) begin
            frame_d   = {{(FRAME_W-1){1'b0}}, card_bit};
            bit_cnt_d = CNT_ONE;
          end
        end
      end

      S_RECV: begin
        if (!card_present) begin
          state_d = S_IDLE;
        end else if (card_bit_valid) begin
          frame_d = {frame_q[FRAME_W-2:0], card_bit};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
      end

      S_CHECK: begin
        if (frame_ok) begin
          code_d  = frame_code;
          retry_d = '0;
          tmo_d   = '0;
          state_d = S_PRESENT;
        end else begin
          state_d = S_REJECT;
        end
      end

      S_PRESENT: begin
        // Card removal wins. After that, an acknowledge beats a timeout
        // that lands in the same cycle.
        if (!card_present) begin
          state_d = S_IDLE;
        end else if (open_access_door) begin
          tmo_d   = '0;
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d = '0;
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RETRY_ONE;
            state_d = S_GAP;
          end else begin
            state_d = S_REJECT;
          end
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      S_GAP: begin
        // One cycle with validate low, so the turnstile sees a new rising edge.
        tmo_d = '0;
        if (!card_present) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PRESENT;
        end
      end

      S_DONE: begin
        if (!open_access_door) begin
          state_d = S_WAIT_OUT;
        end
      end

      S_REJECT: begin
        state_d = S_WAIT_OUT;
      end

      S_WAIT_OUT: begin
        // Frame strobes are ignored until the card has left the slot.
        if (!card_present) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The presented code is forgotten whenever the reader falls back to IDLE.
    if (state_d == S_IDLE) begin
      code_d    = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
      retry_d   = '0;
    end
  end

  // Outputs are decoded from the next state and registered. As a result,
  // validate_code is high from the first PRESENT cycle. Also, reject and
  // validate_code can never be high in the same cycle.
  always_comb begin
    validate_d = (state_d == S_PRESENT);
    reject_d   = (state_d == S_REJECT);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      code_q     <= '0;
      validate_q <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      code_q     <= code_d;
      validate_q <= validate_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign validate_code = validate_q;
  assign access_code   = code_q;
  assign reject        = reject_q;
  assign busy          = busy_q;
  assign state_out     = state_q;

endmodule

// File: doc/metro_card_reader.md
Name: metro_card_reader

Overview:
- Front-end card reader for the metro turnstile; it is the initiator of the turnstile's validate_code/access_code interface.
- Deserialises a 6-bit card frame and checks start and parity bits.
- Presents the 4-bit access code with validate_code held, then waits for open_access_door as the acknowledge, with timeout and retry.
- Rejects bad frames or unacknowledged codes with a one-cycle reject pulse, then waits for card removal.

Parameters:
- CODE_W, 4, access code width; must equal the turnstile's access_code width.
- ACK_TIMEOUT, 8, cycles in PRESENT without open_access_door before the attempt counts as failed (range 1..255).
- MAX_RETRY, 2, re-presentations allowed after the first timeout before reject (range 0..7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rset  input  1  asynchronous, active-low reset.
- card_present  input  1  level, high while a card is in the slot.
- card_bit  input  1  serial frame data, sampled only when card_bit_valid=1.
- card_bit_valid  input  1  one-cycle strobe per frame bit.
- open_access_door  input  1  acknowledge from turnstile; level.
- validate_code  output  1  high while a code is being presented.
- access_code  output  CODE_W  code under presentation; stable while validate_code=1.
- reject  output  1  one-cycle pulse: bad frame or retries exhausted.
- busy  output  1  high in every state except IDLE.
- state_out  output  3  current state encoding, for debug.

Behaviour:
- Reset (rset=0, async): state=IDLE, validate_code=0, access_code=0, reject=0, busy=0, state_out=0, bit/retry/timeout counters=0.
- State encodings: IDLE=0, RECV=1, CHECK=2, PRESENT=3, GAP=4, DONE=5, REJECT=6, WAIT_OUT=7.
- Frame order: bit0 = start (must be 1); bits1..4 = code, MSB first; bit5 = even parity over the code bits. Frame length is CODE_W+2.
- IDLE:
  - Enter RECV when card_present=1.
  - A card_bit_valid in the same cycle is captured as bit0.
- RECV:
  - Each card_bit_valid shifts card_bit in and increments the bit counter.
  - After the last bit, go to CHECK.
  - card_present=0 at any point: go to IDLE, no reject, partial data discarded.
- CHECK (one cycle):
  - Start=1 and parity good: load access_code, clear retry counter, go to PRESENT.
  - Otherwise: go to REJECT.
- PRESENT:
  - validate_code=1 from the first cycle in this state.
  - Timeout counter increments each cycle.
  - open_access_door=1: go to DONE. Acknowledge has priority over timeout in the same cycle.
  - Counter reaches ACK_TIMEOUT:
    - If retry < MAX_RETRY: increment retry, go to GAP.
    - Else: go to REJECT.
  - card_present=0: go to IDLE; validate_code=0 from the next cycle.
- GAP (one cycle): validate_code=0, access_code held, timeout counter cleared, then PRESENT. This gives the turnstile a fresh validate edge.
- DONE:
  - validate_code=0.
  - Go to WAIT_OUT once open_access_door=0.
- REJECT (one cycle): reject=1, validate_code=0, then WAIT_OUT.
- WAIT_OUT:
  - Go to IDLE when card_present=0.
  - card_bit_valid is ignored.
- Outputs are registered.
- access_code clears to 0 only on reset or on entry to IDLE.
- reject is never asserted in the same cycle as validate_code.
- Mid-operation reset from any state: immediate return to reset values; validate_code drops asynchronously.

Test Plan:
1. Reset, then a card with frame 1,1001,0 and turnstile acknowledge 2 cycles after validate rises. Required: validate_code=1 with access_code=4'b1001 until the acknowledge; DONE, then IDLE after door close and card removal; reject never pulses.
2. Frame 1,0000,0 with no acknowledge, default parameters. Required: 3 presentation windows of 8 cycles each, separated by one-cycle validate_code=0 gaps; then reject=1 for exactly one cycle; state_out=7 until card removal.
3. Parity error, frame 1,1001,1. Required: CHECK goes to REJECT; validate_code never rises; one reject pulse.
4. Start error, frame 0,1001,0. Required: reject pulse; access_code stays 0.
5. Card removed after 3 bits. Required: return to IDLE; no reject; no validate_code. A following full valid frame 1,0110,0 presents 4'b0110 correctly.
6. Acknowledge arriving in the timeout cycle. Required: goes to DONE, not GAP. Separately, rset asserted during PRESENT: validate_code=0 immediately, state_out=0.
